// File: rtl/pipeline_hazard_control_if.sv
// Command encoding and signal bundle between the pipeline datapath and the hazard sequencer.
// Purely structural: no storage, no latency.
// The master modport is the datapath side; the slave modport is the sequencer.

package pipeline_hazard_pkg;
  // Per-latch command: ENABLE loads the next stage value, STALL holds the
  // current contents, NOP loads a bubble.
  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'b00,
    PIPE_STALL  = 2'b01,
    PIPE_NOP    = 2'b10
  } pipe_state_t;
endpackage

interface pipeline_hazard_control_if;
  import pipeline_hazard_pkg::*;

  // hazard sources
  logic       ihit;
  logic       dmem_req;
  logic       dhit;
  logic       ex_is_load;
  logic [4:0] ex_rt;
  logic [4:0] dec_rs;
  logic [4:0] dec_rt;
  logic       dec_uses_rt;
  logic       mem_redirect;
  logic       mem_halt;

  // latch commands and PC control
  pipe_state_t fd_state;
  pipe_state_t de_state;
  pipe_state_t em_state;
  pipe_state_t mw_state;
  logic        pc_en;
  logic        pc_redirect;
  logic        halt;

  modport master (
    output ihit, dmem_req, dhit, ex_is_load, ex_rt, dec_rs, dec_rt,
           dec_uses_rt, mem_redirect, mem_halt,
    input  fd_state, de_state, em_state, mw_state, pc_en, pc_redirect, halt
  );

  modport slave (
    input  ihit, dmem_req, dhit, ex_is_load, ex_rt, dec_rs, dec_rt,
           dec_uses_rt, mem_redirect, mem_halt,
    output fd_state, de_state, em_state, mw_state, pc_en, pc_redirect, halt
  );
endinterface

// File: rtl/pipeline_hazard_control.sv
// Five-stage pipeline sequencer: per-latch ENABLE/STALL/NOP, PC enable/redirect, halt drain.
// Zero-cycle decision: commands are combinational from state and inputs; only halt is registered.
// Stalls are issued as commands; PIPELINE_PERF_EN adds saturating stall/flush counters.

module pipeline_hazard_control
  import pipeline_hazard_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  pipeline_hazard_control_if.slave hz
`ifdef PIPELINE_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } seq_state_t;

  seq_state_t  state, state_next;
  logic        halt_q;
  pipe_state_t fd_cmd, de_cmd, em_cmd, mw_cmd;
  logic        pc_en_c, pc_redirect_c;
  logic        stall_evt, flush_evt;

  // raw hazard terms; priority between them is resolved in the decoder
  logic mem_stall, load_use;
  assign mem_stall = hz.dmem_req & ~hz.dhit;
  assign load_use  = hz.ex_is_load & (hz.ex_rt != 5'd0) &
                     ((hz.ex_rt == hz.dec_rs) |
                      (hz.dec_uses_rt & (hz.ex_rt == hz.dec_rt)));

  // sequencer state register; only reset leaves HALTED
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= state_next;
  end

  // halt is high exactly while the sequencer sits in HALTED
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) halt_q <= 1'b0;
    else       halt_q <= (state_next == HALTED);
  end

  // next-state and command decode, RUN conditions in strict priority order
  always_comb begin
    state_next    = state;
    fd_cmd        = PIPE_ENABLE;
    de_cmd        = PIPE_ENABLE;
    em_cmd        = PIPE_ENABLE;
    mw_cmd        = PIPE_ENABLE;
    pc_en_c       = 1'b0;
    pc_redirect_c = 1'b0;
    stall_evt     = 1'b0;
    flush_evt     = 1'b0;
    case (state)
      RUN: begin
        if (hz.mem_halt) begin
          // let the halt itself retire, squash everything younger
          fd_cmd     = PIPE_NOP;
          de_cmd     = PIPE_NOP;
          em_cmd     = PIPE_NOP;
          state_next = DRAIN;
        end else if (mem_stall) begin
          // freeze the front of the pipe; WB gets a bubble
          fd_cmd    = PIPE_STALL;
          de_cmd    = PIPE_STALL;
          em_cmd    = PIPE_STALL;
          mw_cmd    = PIPE_NOP;
          stall_evt = 1'b1;
        end else if (hz.mem_redirect) begin
          // younger instructions and the in-flight fetch are wrong-path
          fd_cmd        = PIPE_NOP;
          de_cmd        = PIPE_NOP;
          em_cmd        = PIPE_NOP;
          pc_en_c       = 1'b1;
          pc_redirect_c = 1'b1;
          flush_evt     = 1'b1;
        end else if (load_use) begin
          // hold DEC one cycle, bubble into EX while the load moves to MEM
          fd_cmd    = PIPE_STALL;
          de_cmd    = PIPE_NOP;
          stall_evt = 1'b1;
        end else if (!hz.ihit) begin
          // no instruction to hand to DEC yet
          fd_cmd    = PIPE_NOP;
          stall_evt = 1'b1;
        end else begin
          pc_en_c = 1'b1;
        end
      end
      DRAIN: begin
        fd_cmd     = PIPE_NOP;
        de_cmd     = PIPE_NOP;
        em_cmd     = PIPE_NOP;
        mw_cmd     = PIPE_NOP;
        state_next = HALTED;
      end
      HALTED: begin
        fd_cmd = PIPE_STALL;
        de_cmd = PIPE_STALL;
        em_cmd = PIPE_STALL;
        mw_cmd = PIPE_STALL;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  assign hz.fd_state    = fd_cmd;
  assign hz.de_state    = de_cmd;
  assign hz.em_state    = em_cmd;
  assign hz.mw_state    = mw_cmd;
  assign hz.pc_en       = pc_en_c;
  assign hz.pc_redirect = pc_redirect_c;
  assign hz.halt        = halt_q;

`ifdef PIPELINE_PERF_EN
  // saturating event counters; events are only raised in RUN so they freeze elsewhere
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall_evt && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (flush_evt && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  logic unused_evt;
  assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Directed bench for pipeline_hazard_control: reset, each hazard class, priority overlaps, halt drain.
// Inputs change 1 ns after CLK rises; outputs are checked 2 ns later, well before the next edge.
// Counter checks are compiled only when PIPELINE_PERF_EN is defined.

module tb_pipeline_hazard_control;
  import pipeline_hazard_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_control_if hz ();

`ifdef PIPELINE_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  pipeline_hazard_control dut (.CLK(CLK), .nRST(nRST), .hz(hz.slave),
                               .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
  pipeline_hazard_control dut (.CLK(CLK), .nRST(nRST), .hz(hz.slave));
`endif

  always #5 CLK = ~CLK;

  localparam logic [1:0] EN = 2'b00;
  localparam logic [1:0] ST = 2'b01;
  localparam logic [1:0] NP = 2'b10;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // compares the four latch commands plus pc_en/pc_redirect as one word
  task automatic check_cmd(input string tag, input logic [1:0] fd, input logic [1:0] de,
                           input logic [1:0] em, input logic [1:0] mw,
                           input logic pe, input logic pr);
    #2;
    check_eq(tag,
             {22'd0, hz.fd_state, hz.de_state, hz.em_state, hz.mw_state, hz.pc_en, hz.pc_redirect},
             {22'd0, fd, de, em, mw, pe, pr});
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    hz.ihit = 1'b1; hz.dmem_req = 1'b0; hz.dhit = 1'b0; hz.ex_is_load = 1'b0;
    hz.ex_rt = 5'd0; hz.dec_rs = 5'd0; hz.dec_rt = 5'd0; hz.dec_uses_rt = 1'b0;
    hz.mem_redirect = 1'b0; hz.mem_halt = 1'b0;
  endtask

  initial begin
    idle();
    // reset: RUN decode of idle inputs, halt low
    check_cmd("reset_cmd", EN, EN, EN, EN, 1'b1, 1'b0);
    check_eq("reset_halt", {31'd0, hz.halt}, 32'd0);
    #15 nRST = 1'b1;
    next_cycle();

    // free-running: everything advances
    for (int i = 0; i < 10; i++) begin
      idle();
      check_cmd("run_idle", EN, EN, EN, EN, 1'b1, 1'b0);
      next_cycle();
    end
    check_eq("run_halt", {31'd0, hz.halt}, 32'd0);
`ifdef PIPELINE_PERF_EN
    check_eq("cnt_idle_stall", stall_cnt, 32'd0);
    check_eq("cnt_idle_flush", flush_cnt, 32'd0);
`endif

    // load-use on rs: one bubble, then clear
    hz.ex_is_load = 1'b1; hz.ex_rt = 5'd5; hz.dec_rs = 5'd5;
    check_cmd("lu_rs", ST, NP, EN, EN, 1'b0, 1'b0);
    next_cycle();
    idle();
    check_cmd("lu_after", EN, EN, EN, EN, 1'b1, 1'b0);
`ifdef PIPELINE_PERF_EN
    check_eq("cnt_lu", stall_cnt, 32'd1);
`endif
    next_cycle();
    // load into r0 never interlocks
    hz.ex_is_load = 1'b1; hz.ex_rt = 5'd0; hz.dec_rs = 5'd0; hz.dec_rt = 5'd0; hz.dec_uses_rt = 1'b1;
    check_cmd("lu_r0", EN, EN, EN, EN, 1'b1, 1'b0);
    next_cycle();
    // match on rt only counts when DEC reads rt
    hz.ex_rt = 5'd7; hz.dec_rs = 5'd3; hz.dec_rt = 5'd7; hz.dec_uses_rt = 1'b1;
    check_cmd("lu_rt", ST, NP, EN, EN, 1'b0, 1'b0);
    hz.dec_uses_rt = 1'b0;
    check_cmd("lu_rt_unused", EN, EN, EN, EN, 1'b1, 1'b0);
    next_cycle();

    // icache miss
    idle(); hz.ihit = 1'b0;
    check_cmd("imiss", NP, EN, EN, EN, 1'b0, 1'b0);
    next_cycle();
`ifdef PIPELINE_PERF_EN
    check_eq("cnt_imiss", stall_cnt, 32'd2);
`endif

    // dcache miss for 3 cycles, redirect pending during the middle one
    for (int i = 0; i < 3; i++) begin
      idle(); hz.dmem_req = 1'b1; hz.dhit = 1'b0; hz.mem_redirect = (i == 1);
      check_cmd("dmiss", ST, ST, ST, NP, 1'b0, 1'b0);
      next_cycle();
    end
    idle(); hz.dmem_req = 1'b1; hz.dhit = 1'b1;
    check_cmd("dhit", EN, EN, EN, EN, 1'b1, 1'b0);
    next_cycle();
`ifdef PIPELINE_PERF_EN
    check_eq("cnt_dmiss", stall_cnt, 32'd5);
    check_eq("cnt_dmiss_flush", flush_cnt, 32'd0);
`endif

    // redirect beats icache miss and load-use
    idle(); hz.mem_redirect = 1'b1; hz.ihit = 1'b0;
    hz.ex_is_load = 1'b1; hz.ex_rt = 5'd9; hz.dec_rs = 5'd9;
    check_cmd("redirect", NP, NP, NP, EN, 1'b1, 1'b1);
    next_cycle();
`ifdef PIPELINE_PERF_EN
    check_eq("cnt_redir_flush", flush_cnt, 32'd1);
    check_eq("cnt_redir_stall", stall_cnt, 32'd5);
`endif

    // halt beats a concurrent dcache miss and redirect
    idle(); hz.mem_halt = 1'b1; hz.dmem_req = 1'b1; hz.mem_redirect = 1'b1;
    check_cmd("halt_c0", NP, NP, NP, EN, 1'b0, 1'b0);
    check_eq("halt_c0_flag", {31'd0, hz.halt}, 32'd0);
    next_cycle();
    idle();
    check_cmd("halt_c1", NP, NP, NP, NP, 1'b0, 1'b0);
    check_eq("halt_c1_flag", {31'd0, hz.halt}, 32'd0);
    next_cycle();
    for (int i = 0; i < 20; i++) begin
      hz.ihit = i[0]; hz.mem_redirect = i[1]; hz.mem_halt = i[2];
      hz.dmem_req = i[0]; hz.dhit = i[3];
      check_cmd("halted", ST, ST, ST, ST, 1'b0, 1'b0);
      check_eq("halted_flag", {31'd0, hz.halt}, 32'd1);
      next_cycle();
    end
`ifdef PIPELINE_PERF_EN
    check_eq("cnt_halt_stall", stall_cnt, 32'd5);
    check_eq("cnt_halt_flush", flush_cnt, 32'd1);
`endif

    // asynchronous reset out of HALTED
    idle();
    #1 nRST = 1'b0;
    #1;
    check_eq("rst_halt", {31'd0, hz.halt}, 32'd0);
    check_cmd("rst_cmd", EN, EN, EN, EN, 1'b1, 1'b0);
`ifdef PIPELINE_PERF_EN
    check_eq("rst_cnt", stall_cnt | flush_cnt, 32'd0);
`endif
    next_cycle();
    nRST = 1'b1;
    next_cycle();
    check_cmd("post_rst", EN, EN, EN, EN, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
